// File: rtl/seq_det_pkg.sv
// Shared types and limits for the serial pattern detectors.
package seq_det_pkg;

  // Detector FSM: collecting bits until a full window is held, then comparing.
  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } seq_state_t;

  // Legal range of the pattern length.
  localparam int SEQ_W_MIN = 2;
  localparam int SEQ_W_MAX = 16;

  // Legal range of the hit counter width.
  localparam int SEQ_CNT_W_MIN = 1;
  localparam int SEQ_CNT_W_MAX = 32;

endpackage

// File: rtl/seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; reusable by any detector.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  // Next count: clear wins, otherwise step up unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/seq_detector.sv
// Programmable serial pattern detector with overlap control and hit counting.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [W-1:0]     pattern,
  input  logic             overlap,
  input  logic             clear,
  output logic             match,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  // Width of the fill counter, which must be able to hold the value W.
  localparam int FW = $clog2(W + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(W);

  // Out-of-range parameters are rejected at elaboration.
  if ((W < SEQ_W_MIN) || (W > SEQ_W_MAX)) begin : g_bad_w
    $error("seq_detector: W out of range");
  end
  if ((CNT_W < SEQ_CNT_W_MIN) || (CNT_W > SEQ_CNT_W_MAX)) begin : g_bad_cnt_w
    $error("seq_detector: CNT_W out of range");
  end

  logic [W-1:0]  hist_d;
  logic [W-1:0]  hist_q;
  logic [FW-1:0] fill_d;
  logic [FW-1:0] fill_q;
  seq_state_t    state_d;
  seq_state_t    state_q;
  logic          match_d;
  logic          match_q;

  logic [W-1:0]  hist_n;
  logic [FW-1:0] fill_n;
  logic          hit;

  // Candidate window and fill level if the current bit were accepted.
  always_comb begin
    hist_n = {hist_q[W-2:0], in_bit};
    fill_n = (fill_q == FILL_FULL) ? FILL_FULL : (fill_q + FW'(1));
  end

  // Next-state logic; clear discards the incoming bit and restores reset state.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    state_d = state_q;
    match_d = 1'b0;
    hit     = 1'b0;
    if (clear) begin
      hist_d  = '0;
      fill_d  = '0;
      state_d = FILL;
    end else if (in_valid) begin
      hist_d  = hist_n;
      hit     = (fill_n == FILL_FULL) && (hist_n == pattern);
      match_d = hit;
      if (hit && !overlap) begin
        fill_d  = '0;
        state_d = FILL;
      end else begin
        fill_d = fill_n;
        if (fill_n == FILL_FULL) begin
          state_d = ARMED;
        end
      end
    end
  end

  // Detector state and registered match pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= FILL;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_hit_cnt (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .inc  (hit),
    .count(match_cnt)
  );

  assign match = match_q;
  assign armed = (state_q == ARMED);

endmodule

// File: tb/tb_seq_detector.sv
// Directed testbench for seq_detector: a W=4 instance and a W=2/CNT_W=2 instance.
module tb_seq_detector;

  logic clk;
  logic rst;

  // Instance A: W=4, CNT_W=8
  logic       a_valid, a_bit, a_overlap, a_clear;
  logic [3:0] a_pattern;
  logic       a_match, a_armed;
  logic [7:0] a_cnt;

  // Instance B: W=2, CNT_W=2
  logic       b_valid, b_bit, b_overlap, b_clear;
  logic [1:0] b_pattern;
  logic       b_match, b_armed;
  logic [1:0] b_cnt;

  int checksTotal;
  int checksPassed;

  seq_detector #(.W(4), .CNT_W(8)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .in_valid (a_valid),
    .in_bit   (a_bit),
    .pattern  (a_pattern),
    .overlap  (a_overlap),
    .clear    (a_clear),
    .match    (a_match),
    .armed    (a_armed),
    .match_cnt(a_cnt)
  );

  seq_detector #(.W(2), .CNT_W(2)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .in_valid (b_valid),
    .in_bit   (b_bit),
    .pattern  (b_pattern),
    .overlap  (b_overlap),
    .clear    (b_clear),
    .match    (b_match),
    .armed    (b_armed),
    .match_cnt(b_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checksTotal++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      checksPassed++;
    end
  endtask

  // Drive one cycle of inputs into instance A and sample 1 time unit after the edge.
  task automatic applyStimulus(input logic v, input logic b, input logic clr);
    a_valid = v;
    a_bit   = b;
    a_clear = clr;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_clear = 1'b0;
  endtask

  // Same for instance B.
  task automatic stepB(input logic v, input logic b);
    b_valid = v;
    b_bit   = b;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
  endtask

  // Feed a 7-bit stream (MSB first) into A with optional idle gaps, checking match/armed after each bit.
  task automatic runStream(input string name, input logic [6:0] s, input logic [6:0] expM,
                           input logic [6:0] expA, input int gap);
    for (int i = 6; i >= 0; i--) begin
      applyStimulus(1'b1, s[i], 1'b0);
      checkOutput($sformatf("%s_match_bit%0d", name, 7 - i), {31'd0, a_match}, {31'd0, expM[i]});
      checkOutput($sformatf("%s_armed_bit%0d", name, 7 - i), {31'd0, a_armed}, {31'd0, expA[i]});
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput($sformatf("%s_gap_match_bit%0d_%0d", name, 7 - i, g), {31'd0, a_match}, 32'd0);
      end
    end
  endtask

  initial begin
    logic [6:0] stream;
    logic [3:0] seqA;
    checksTotal  = 0;
    checksPassed = 0;
    rst       = 1'b0;
    a_valid   = 1'b0; a_bit = 1'b0; a_clear = 1'b0; a_overlap = 1'b1; a_pattern = 4'b1011;
    b_valid   = 1'b0; b_bit = 1'b0; b_clear = 1'b0; b_overlap = 1'b1; b_pattern = 2'b11;
    stream    = 7'b1011011;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_match", {31'd0, a_match}, 32'd0);
    checkOutput("reset_armed", {31'd0, a_armed}, 32'd0);
    checkOutput("reset_cnt",   {24'd0, a_cnt},   32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Overlapping detection: hits after bits 4 and 7
    a_overlap = 1'b1;
    runStream("ovl", stream, 7'b0001001, 7'b0001111, 0);
    checkOutput("ovl_cnt", {24'd0, a_cnt}, 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ovl_idle_match", {31'd0, a_match}, 32'd0);

    // Clear restores reset state
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clr1_cnt",   {24'd0, a_cnt},   32'd0);
    checkOutput("clr1_armed", {31'd0, a_armed}, 32'd0);

    // Non-overlapping: single hit, fill restarts so armed is low through bit 7
    a_overlap = 1'b0;
    runStream("novl", stream, 7'b0001000, 7'b0000000, 0);
    checkOutput("novl_cnt", {24'd0, a_cnt}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("novl_bit8_match", {31'd0, a_match}, 32'd0);
    checkOutput("novl_bit8_armed", {31'd0, a_armed}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Overlapping with three idle cycles after every bit
    a_overlap = 1'b1;
    runStream("gap", stream, 7'b0001001, 7'b0001111, 3);
    checkOutput("gap_cnt", {24'd0, a_cnt}, 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Clear together with the completing bit discards it
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("clrbit_match", {31'd0, a_match}, 32'd0);
    checkOutput("clrbit_cnt",   {24'd0, a_cnt},   32'd0);
    checkOutput("clrbit_armed", {31'd0, a_armed}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("clrbit_post3_match", {31'd0, a_match}, 32'd0);
    checkOutput("clrbit_post3_armed", {31'd0, a_armed}, 32'd0);
    seqA = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(1'b1, seqA[i], 1'b0);
      checkOutput($sformatf("clrbit_tail_match%0d", 4 - i), {31'd0, a_match}, {31'd0, (i == 0)});
      checkOutput($sformatf("clrbit_tail_armed%0d", 4 - i), {31'd0, a_armed}, 32'd1);
    end
    checkOutput("clrbit_tail_cnt", {24'd0, a_cnt}, 32'd1);

    // Asynchronous reset mid-stream after three bits of 1011
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("prerst_armed", {31'd0, a_armed}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_async_match", {31'd0, a_match}, 32'd0);
    checkOutput("rst_async_armed", {31'd0, a_armed}, 32'd0);
    checkOutput("rst_async_cnt",   {24'd0, a_cnt},   32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(1'b1, seqA[i], 1'b0);
      checkOutput($sformatf("postrst_match%0d", 4 - i), {31'd0, a_match}, {31'd0, (i == 0)});
    end
    checkOutput("postrst_cnt", {24'd0, a_cnt}, 32'd1);

    // Instance B: pattern 11 with six 1s, counter saturates at 3
    for (int i = 1; i <= 6; i++) begin
      stepB(1'b1, 1'b1);
      checkOutput($sformatf("sat_match%0d", i), {31'd0, b_match}, {31'd0, (i >= 2)});
      checkOutput($sformatf("sat_cnt%0d", i), {30'd0, b_cnt},
                  (i <= 1) ? 32'd0 : ((i >= 4) ? 32'd3 : 32'(i - 1)));
    end
    stepB(1'b1, 1'b0);
    checkOutput("sat_end_match", {31'd0, b_match}, 32'd0);
    checkOutput("sat_end_cnt",   {30'd0, b_cnt},   32'd3);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
